gcd_controller: RTL
===================

# gcd_controller

Sequencing FSM for the 8-bit subtractive GCD datapath. It accepts two operands over a valid/ready handshake and steers them onto the shared bus into registers A and B. It then issues one compare-and-subtract step per cycle until the comparator reports equality, and signals completion with a done pulse. An iteration counter bounds the loop; non-terminating inputs such as a zero operand end with an error flag instead of hanging.

## Interface

Parameters:
- ITER_W, 8, width of the iteration counter
- MAX_ITER, 255, maximum subtractions before timeout; must fit in ITER_W bits

Ports:
- clk  input  1  single clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand word present on the datapath data bus
- in_ready  output  1  controller accepts the operand this cycle
- gt, lt, eq  input  1 each  comparator outputs for A vs B
- ldA, ldB  output  1 each  load enables for registers A and B
- sel_in  output  1  bus source select: 1 selects external data, 0 selects subtractor result
- sel1  output  1  subtractor X operand select: 0 selects A, 1 selects B
- sel2  output  1  subtractor Y operand select: 0 selects A, 1 selects B
- busy  output  1  high from first operand accept until DONE
- done  output  1  one-cycle completion pulse
- err  output  1  timeout flag; valid when done=1, held until next operand A accept
- iter_count  output  ITER_W  subtractions performed in current/last run

## Operation

- States: IDLE, LOAD_B, COMPARE, DONE. Two-bit state register.
- Control outputs are combinational decodes of the state register plus in_valid/gt/lt/eq. Undriven enables are 0. Selects are 0 when unused.
- IDLE: in_ready=1. If in_valid, then sel_in=1 and ldA=1. Also clear iter_count and err, set busy, and go to LOAD_B.
- LOAD_B: in_ready=1. If in_valid, then sel_in=1 and ldB=1, and go to COMPARE. Without in_valid, remain in LOAD_B indefinitely.
- COMPARE: in_ready=0, sel_in=0. Priority is eq > timeout > gt > lt.
  - eq: no load; go to DONE, err=0.
  - Timeout (iter_count == MAX_ITER and not eq): no load; go to DONE, set err=1.
  - gt: sel1=0, sel2=1, ldA=1 (A <= A−B). Increment iter_count; stay.
  - lt: sel1=1, sel2=0, ldB=1 (B <= B−A). Increment iter_count; stay.
  - None of gt/lt/eq asserted: treat as eq.
- DONE: done=1, in_ready=0, busy=0; next state IDLE unconditionally. The result (the GCD) is in A and B. Both registers hold until the next operand load.
- iter_count saturates at MAX_ITER; it never wraps.
- in_valid during COMPARE or DONE is ignored (in_ready=0); the source must hold data.
- Zero-operand behaviour:
  - A=0, B=0: eq immediately; done with err=0 and iter_count=0.
  - A=0, B>0 (or the mirror case): no progress; terminates by timeout with err=1.

## Timing

- Reset values: state=IDLE, busy=0, done=0, err=0, iter_count=0, and all load enables 0. in_ready=1 after reset since IDLE decodes it.
- rst asserted in any state, including mid-COMPARE: next edge forces IDLE with the values above. Datapath registers are not cleared by this block.
- Operand A is written at the edge ending the accept cycle. Operand B is written one or more cycles later.
- Comparator outputs are valid the cycle after any load. One subtraction per COMPARE cycle.
- Latency: if B is accepted in cycle t and N subtractions are needed, COMPARE occupies cycles t+1 … t+N+1 and done=1 in cycle t+N+2.
- Timeout run: done at t+MAX_ITER+2, with err=1 and iter_count=MAX_ITER.
- Back-to-back: a new operand A can be accepted in the cycle immediately after done.

## Test plan

- Reset: hold rst 2 cycles, including once mid-COMPARE on operands (200,3). Require state IDLE, busy=0, done=0, err=0, iter_count=0 and in_ready=1 on the cycle after release.
- Basic (12,18), in_valid on consecutive cycles from cycle 0:
  - ldB with sel1=1/sel2=0 in cycle 2, then ldA with sel1=0/sel2=1 in cycle 3.
  - done in cycle 5 with A=B=6, iter_count=2, err=0.
- Worst-case legal (255,1): 254 subtractions, A=B=1, done 256 cycles after B accept, err=0.
- Zero operands:
  - (0,0): done 2 cycles after B accept, iter_count=0, err=0.
  - (0,7): done 257 cycles after B accept, err=1, iter_count=255, B unchanged at 7.
- Handshake gaps: in_valid low for 3 cycles between A and B, and asserted again during COMPARE. Require no ldA/ldB from the data bus except on in_valid&in_ready cycles, and the result gcd(48,36)=12 unaffected.
- Back-to-back: (9,6) then (17,51) with the second A presented on the cycle right after done. Require the second A accepted immediately, err/iter_count cleared on accept, and second result 17 with iter_count=2.

Source files
------------

// File: rtl/gcd_controller.sv
// Sequencing FSM for an 8-bit subtractive GCD datapath.
// Two operands arrive over a valid/ready handshake and are loaded into A and B.
// The FSM then issues one compare-and-subtract step per cycle until the
// comparator reports equality. An iteration bound turns non-terminating
// inputs, such as a zero operand, into an error completion instead of a hang.
module gcd_controller #(
    parameter int ITER_W   = 8,
    parameter int MAX_ITER = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              gt,
    input  logic              lt,
    input  logic              eq,
    output logic              ldA,
    output logic              ldB,
    output logic              sel_in,
    output logic              sel1,
    output logic              sel2,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ITER_W-1:0] iter_count
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD_B  = 2'd1,
        S_COMPARE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [ITER_W-1:0] MAX_ITER_C = ITER_W'(MAX_ITER);
    localparam logic [ITER_W-1:0] ONE_C      = ITER_W'(1);

    state_t            r_state;
    logic              r_busy;
    logic              r_err;
    logic [ITER_W-1:0] r_iter;

    logic              w_timeout;
    logic              w_settled;

    // A missing comparator decision is treated like equality so the loop ends.
    assign w_timeout = (r_iter == MAX_ITER_C);
    assign w_settled = eq | ~(gt | lt);

    // State register plus the status registers busy, err and iter_count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
            r_iter  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_state <= S_LOAD_B;
                        r_busy  <= 1'b1;
                        r_err   <= 1'b0;
                        r_iter  <= '0;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_LOAD_B: begin
                    if (in_valid) begin
                        r_state <= S_COMPARE;
                    end else begin
                        r_state <= S_LOAD_B;
                    end
                end
                S_COMPARE: begin
                    if (w_settled) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_err   <= 1'b0;
                    end else if (w_timeout) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_err   <= 1'b1;
                    end else begin
                        r_state <= S_COMPARE;
                        // Saturating count; the timeout branch normally stops it first.
                        if (r_iter != MAX_ITER_C) begin
                            r_iter <= r_iter + ONE_C;
                        end else begin
                            r_iter <= r_iter;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_err   <= 1'b0;
                    r_iter  <= '0;
                end
            endcase
        end
    end

    // Datapath control decode from the current state and handshake/comparator inputs.
    always_comb begin
        in_ready = 1'b0;
        ldA      = 1'b0;
        ldB      = 1'b0;
        sel_in   = 1'b0;
        sel1     = 1'b0;
        sel2     = 1'b0;
        done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    sel_in = 1'b1;
                    ldA    = 1'b1;
                end else begin
                    sel_in = 1'b0;
                end
            end
            S_LOAD_B: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    sel_in = 1'b1;
                    ldB    = 1'b1;
                end else begin
                    sel_in = 1'b0;
                end
            end
            S_COMPARE: begin
                if (w_settled || w_timeout) begin
                    ldA = 1'b0;
                end else if (gt) begin
                    // A <= A - B
                    sel1 = 1'b0;
                    sel2 = 1'b1;
                    ldA  = 1'b1;
                end else begin
                    // B <= B - A
                    sel1 = 1'b1;
                    sel2 = 1'b0;
                    ldB  = 1'b1;
                end
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                done = 1'b0;
            end
        endcase
    end

    assign busy       = r_busy;
    assign err        = r_err;
    assign iter_count = r_iter;

endmodule
